alu_share_arbiter: RTL and testbench

- Shares one combinational ALU (4-bit op code, two 32-bit operands, 32-bit result, 1-bit branch condition) between two requesters, port 0 and port 1.
- Each requester issues an op through a valid/ready request channel and gets the result back through a registered valid/ready response channel.
- Sits between the ALU and the two datapath clients, for example a main execute stage and a branch/address helper unit in the multi-cycle core.

---
 rtl/alu_share_arbiter.sv | 179 +++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters.
// Each port has a valid/ready request channel and a registered valid/ready
// response channel. Round-robin between the ports when both are eligible.
// A port that still holds an unconsumed response is not eligible.
// Optional statistics counters are enabled by defining ALU_SHARE_ARBITER_STATS_EN.
module alu_share_arbiter #(
    parameter int DATA_W = 32
`ifdef ALU_SHARE_ARBITER_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_op,
    input  logic [DATA_W-1:0] req0_in_1,
    input  logic [DATA_W-1:0] req0_in_2,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [DATA_W-1:0] resp0_result,
    output logic              resp0_bcond,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_op,
    input  logic [DATA_W-1:0] req1_in_1,
    input  logic [DATA_W-1:0] req1_in_2,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_result,
    output logic              resp1_bcond,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_in_1,
    output logic [DATA_W-1:0] alu_in_2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_bcond
`ifdef ALU_SHARE_ARBITER_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_grant0,
    output logic [CNT_W-1:0]  stat_grant1,
    output logic [CNT_W-1:0]  stat_conflict
`endif
);

    logic [1:0]        req_valid;
    logic [1:0]        resp_ready;
    logic [1:0]        elig;
    logic [1:0]        grant;

    logic [1:0]        resp_valid_q, resp_valid_d;
    logic [1:0]        resp_bcond_q, resp_bcond_d;
    logic [DATA_W-1:0] resp_result_q [2];
    logic [DATA_W-1:0] resp_result_d [2];
    logic              last_grant_q, last_grant_d;

    assign req_valid  = {req1_valid, req0_valid};
    assign resp_ready = {resp1_ready, resp0_ready};

    // Eligibility and round-robin grant; the port that did not win last time wins a contest.
    always_comb begin
        elig  = req_valid & ~resp_valid_q & {2{reset}};
        grant = 2'b00;
        if (elig == 2'b11) begin
            grant = last_grant_q ? 2'b01 : 2'b10;
        end else begin
            grant = elig;
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // Route the winning request to the ALU; idle drives ADD with zero operands.
    always_comb begin
        alu_op   = 4'b0000;
        alu_in_1 = '0;
        alu_in_2 = '0;
        if (grant[0]) begin
            alu_op   = req0_op;
            alu_in_1 = req0_in_1;
            alu_in_2 = req0_in_2;
        end else if (grant[1]) begin
            alu_op   = req1_op;
            alu_in_1 = req1_in_1;
            alu_in_2 = req1_in_2;
        end
    end

    // Next-state for the response registers and the round-robin pointer.
    always_comb begin
        resp_valid_d  = resp_valid_q;
        resp_bcond_d  = resp_bcond_q;
        last_grant_d  = last_grant_q;
        for (int i = 0; i < 2; i++) begin
            resp_result_d[i] = resp_result_q[i];
            if (grant[i]) begin
                resp_valid_d[i]  = 1'b1;
                resp_result_d[i] = alu_result;
                resp_bcond_d[i]  = alu_bcond;
            end else if (resp_valid_q[i] && resp_ready[i]) begin
                resp_valid_d[i]  = 1'b0;
                resp_result_d[i] = '0;
                resp_bcond_d[i]  = 1'b0;
            end
        end
        if (grant[0]) begin
            last_grant_d = 1'b0;
        end else if (grant[1]) begin
            last_grant_d = 1'b1;
        end
    end

    // Response and pointer registers; active-low synchronous clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            resp_valid_q     <= 2'b00;
            resp_bcond_q     <= 2'b00;
            resp_result_q[0] <= '0;
            resp_result_q[1] <= '0;
            last_grant_q     <= 1'b1;
        end else begin
            resp_valid_q     <= resp_valid_d;
            resp_bcond_q     <= resp_bcond_d;
            resp_result_q[0] <= resp_result_d[0];
            resp_result_q[1] <= resp_result_d[1];
            last_grant_q     <= last_grant_d;
        end
    end

    assign resp0_valid  = resp_valid_q[0];
    assign resp1_valid  = resp_valid_q[1];
    assign resp0_result = resp_result_q[0];
    assign resp1_result = resp_result_q[1];
    assign resp0_bcond  = resp_bcond_q[0];
    assign resp1_bcond  = resp_bcond_q[1];

`ifdef ALU_SHARE_ARBITER_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] stat_grant0_q, stat_grant0_d;
    logic [CNT_W-1:0] stat_grant1_q, stat_grant1_d;
    logic [CNT_W-1:0] stat_conflict_q, stat_conflict_d;

    // Saturating event counters for accepts per port and contested cycles.
    always_comb begin
        stat_grant0_d   = stat_grant0_q;
        stat_grant1_d   = stat_grant1_q;
        stat_conflict_d = stat_conflict_q;
        if (grant[0] && stat_grant0_q != CNT_MAX) begin
            stat_grant0_d = stat_grant0_q + 1'b1;
        end
        if (grant[1] && stat_grant1_q != CNT_MAX) begin
            stat_grant1_d = stat_grant1_q + 1'b1;
        end
        if ((elig == 2'b11) && stat_conflict_q != CNT_MAX) begin
            stat_conflict_d = stat_conflict_q + 1'b1;
        end
    end

    // Counter registers; cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_grant0_q   <= '0;
            stat_grant1_q   <= '0;
            stat_conflict_q <= '0;
        end else begin
            stat_grant0_q   <= stat_grant0_d;
            stat_grant1_q   <= stat_grant1_d;
            stat_conflict_q <= stat_conflict_d;
        end
    end

    assign stat_grant0   = stat_grant0_q;
    assign stat_grant1   = stat_grant1_q;
    assign stat_conflict = stat_conflict_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed test-plan sequences followed by random
// traffic, all checked against a transaction-level reference model.
module tb_alu_share_arbiter;

    localparam int DW = 32;
`ifdef ALU_SHARE_ARBITER_STATS_EN
    localparam int CW = 4;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_bcond;
    logic [3:0]    req0_op;
    logic [DW-1:0] req0_in_1, req0_in_2, resp0_result;
    logic          req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_bcond;
    logic [3:0]    req1_op;
    logic [DW-1:0] req1_in_1, req1_in_2, resp1_result;
    logic [3:0]    alu_op;
    logic [DW-1:0] alu_in_1, alu_in_2, alu_result;
    logic          alu_bcond;
`ifdef ALU_SHARE_ARBITER_STATS_EN
    logic [CW-1:0] stat_grant0, stat_grant1, stat_conflict;
`endif

    always #5 clk = ~clk;

    alu_share_arbiter #(
        .DATA_W(DW)
`ifdef ALU_SHARE_ARBITER_STATS_EN
        , .CNT_W(CW)
`endif
    ) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_in_1(req0_in_1), .req0_in_2(req0_in_2),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp0_result(resp0_result), .resp0_bcond(resp0_bcond),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_in_1(req1_in_1), .req1_in_2(req1_in_2),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp1_result(resp1_result), .resp1_bcond(resp1_bcond),
        .alu_op(alu_op), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
        .alu_result(alu_result), .alu_bcond(alu_bcond)
`ifdef ALU_SHARE_ARBITER_STATS_EN
        , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1),
        .stat_conflict(stat_conflict)
`endif
    );

    // Reference ALU: {bcond, result}
    function automatic logic [32:0] alu_ref(input logic [3:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [32:0] r;
        r = '0;
        case (op)
            4'd0:  r[31:0] = a + b;
            4'd1:  r[31:0] = a - b;
            4'd2:  r[31:0] = a & b;
            4'd3:  r[31:0] = a | b;
            4'd4:  r[31:0] = a ^ b;
            4'd5:  r[31:0] = a << b[4:0];
            4'd6:  r[31:0] = a >> b[4:0];
            4'd7:  r[32]   = (a == b);
            4'd8:  r[32]   = (a != b);
            4'd9:  r[32]   = ($signed(a) <  $signed(b));
            4'd10: r[32]   = ($signed(a) >= $signed(b));
            default: r = '0;
        endcase
        return r;
    endfunction

    // Behavioural ALU attached to the DUT's ALU port
    always_comb begin
        {alu_bcond, alu_result} = alu_ref(alu_op, alu_in_1, alu_in_2);
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Transaction-level model state
    bit          m_valid [2];
    logic [31:0] m_res   [2];
    bit          m_bc    [2];
    int          m_last;
    int          m_g0, m_g1, m_cf;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 0;
            m_res[i]   = '0;
            m_bc[i]    = 0;
        end
        m_last = 1;
        m_g0 = 0; m_g1 = 0; m_cf = 0;
    endtask

    function automatic int sat(input int v);
`ifdef ALU_SHARE_ARBITER_STATS_EN
        return (v >= (1 << CW) - 1) ? (1 << CW) - 1 : v + 1;
`else
        return v + 1;
`endif
    endfunction

    // One clock: check grant/ALU drive, take the edge, update the model, check responses.
    task automatic step();
        int          g;
        bit          e0, e1, rdy0, rdy1;
        logic [3:0]  eop;
        logic [31:0] ea, eb;
        logic [32:0] r;
        #1;
        e0 = req0_valid && !m_valid[0] && reset;
        e1 = req1_valid && !m_valid[1] && reset;
        if (e0 && e1)  g = (m_last == 0) ? 1 : 0;
        else if (e0)   g = 0;
        else if (e1)   g = 1;
        else           g = -1;
        eop = 4'd0; ea = '0; eb = '0;
        if (g == 0) begin eop = req0_op; ea = req0_in_1; eb = req0_in_2; end
        if (g == 1) begin eop = req1_op; ea = req1_in_1; eb = req1_in_2; end
        check("req0_ready", 64'(req0_ready), 64'(g == 0));
        check("req1_ready", 64'(req1_ready), 64'(g == 1));
        check("alu_op",     64'(alu_op),     64'(eop));
        check("alu_in_1",   64'(alu_in_1),   64'(ea));
        check("alu_in_2",   64'(alu_in_2),   64'(eb));
        rdy0 = resp0_ready;
        rdy1 = resp1_ready;
        @(posedge clk);
        cyc++;
        if (!reset) begin
            model_clear();
        end else begin
            if (e0 && e1) m_cf = sat(m_cf);
            if (m_valid[0] && rdy0) begin m_valid[0] = 0; m_res[0] = '0; m_bc[0] = 0; end
            if (m_valid[1] && rdy1) begin m_valid[1] = 0; m_res[1] = '0; m_bc[1] = 0; end
            if (g >= 0) begin
                r = alu_ref(eop, ea, eb);
                m_valid[g] = 1;
                m_res[g]   = r[31:0];
                m_bc[g]    = r[32];
                m_last     = g;
                if (g == 0) m_g0 = sat(m_g0); else m_g1 = sat(m_g1);
                $display("[TB] cycle %0d grant port %0d op=%0d a=%0h b=%0h -> result=%0h bcond=%0d",
                         cyc, g, eop, ea, eb, r[31:0], r[32]);
            end
        end
        @(negedge clk);
        check("resp0_valid",  64'(resp0_valid),  64'(m_valid[0]));
        check("resp0_result", 64'(resp0_result), 64'(m_res[0]));
        check("resp0_bcond",  64'(resp0_bcond),  64'(m_bc[0]));
        check("resp1_valid",  64'(resp1_valid),  64'(m_valid[1]));
        check("resp1_result", 64'(resp1_result), 64'(m_res[1]));
        check("resp1_bcond",  64'(resp1_bcond),  64'(m_bc[1]));
`ifdef ALU_SHARE_ARBITER_STATS_EN
        check("stat_grant0",   64'(stat_grant0),   64'(m_g0));
        check("stat_grant1",   64'(stat_grant1),   64'(m_g1));
        check("stat_conflict", 64'(stat_conflict), 64'(m_cf));
`endif
    endtask

    task automatic drive(input int p, input bit v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            req0_valid = v; req0_op = op; req0_in_1 = a; req0_in_2 = b;
        end else begin
            req1_valid = v; req1_op = op; req1_in_1 = a; req1_in_2 = b;
        end
    endtask

    initial begin
        reset = 1'b0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        drive(0, 0, 4'd0, 0, 0);
        drive(1, 0, 4'd0, 0, 0);
        model_clear();
        @(negedge clk);
        step();
        step();
        reset = 1'b1;

        // Single op on port 0: 5 + 7
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        drive(0, 1, 4'd0, 5, 7);
        step();
        check("tp1_result", 64'(resp0_result), 64'd12);
        drive(0, 0, 4'd0, 0, 0);
        step();
        step();

        // Contest just after reset: port 0 first, then port 1
        reset = 1'b0; step(); reset = 1'b1;
        drive(0, 1, 4'd1, 10, 3);
        drive(1, 1, 4'd7, 4, 4);
        step();
        check("tp2_result0", 64'(resp0_result), 64'd7);
        drive(0, 0, 4'd0, 0, 0);
        step();
        check("tp2_bcond1", 64'(resp1_bcond), 64'd1);
        drive(1, 0, 4'd0, 0, 0);
        step();

        // Port 1 holds its response; port 0 keeps getting service
        resp1_ready = 1'b0;
        drive(1, 1, 4'd5, 1, 4);
        step();
        drive(1, 1, 4'd0, 9, 9);
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 4'd2, $urandom, $urandom);
            step();
            check("tp3_hold", 64'(resp1_result), 64'd16);
        end
        resp1_ready = 1'b1;
        drive(0, 0, 4'd0, 0, 0);
        step();
        step();
        drive(1, 0, 4'd0, 0, 0);
        step();

        // Both continuously valid: strict alternation
        for (int k = 0; k < 8; k++) begin
            drive(0, 1, 4'($urandom_range(0, 10)), $urandom, $urandom);
            drive(1, 1, 4'($urandom_range(0, 10)), $urandom, $urandom);
            step();
        end
        drive(0, 0, 4'd0, 0, 0);
        drive(1, 0, 4'd0, 0, 0);
        step();
        step();

        // BLT accepted, then reset before the response is consumed
        resp0_ready = 1'b0;
        drive(0, 1, 4'd9, 2, 3);
        step();
        check("tp5_bcond", 64'(resp0_bcond), 64'd1);
        drive(0, 0, 4'd0, 0, 0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        resp0_ready = 1'b1;
        drive(0, 1, 4'd0, 1, 1);
        drive(1, 1, 4'd0, 2, 2);
        step();

        // Random traffic
        for (int k = 0; k < 500; k++) begin
            reset       = ($urandom_range(0, 99) >= 2);
            resp0_ready = ($urandom_range(0, 9) < 7);
            resp1_ready = ($urandom_range(0, 9) < 7);
            for (int p = 0; p < 2; p++) begin
                logic [31:0] a, b;
                a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
                b = ($urandom_range(0, 3) == 0) ? a : $urandom;
                drive(p, $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), a, b);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
